// File: rtl/sync_memory.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
// Define SYNC_MEMORY_CLEAR_EN to have reset also clear every array word.
module sync_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rw_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_wr;
  logic                  w_rd;

  assign w_wr = en_i & rw_i;
  assign w_rd = en_i & ~rw_i;

`ifdef SYNC_MEMORY_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[addr_i] <= data_i;
    end
  end
`else
  // NOTE: the array has no reset so it maps onto plain block RAM; rst only
  // gates the write enable so a write sampled during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      r_mem[addr_i] <= data_i;
    end
  end
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_data <= r_mem[addr_i];
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_sync_memory.sv
// Self-checking bench for sync_memory: directed vector table plus hand-written
// sequences for reset, full sweep and mid-stream reset.
module tb_sync_memory;

  logic       clk;
  logic       rst;
  logic [3:0] addr_i;
  logic       rw_i;
  logic       en_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       valid_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  sync_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr_i),
    .rw_i    (rw_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one access, let it be sampled, and land 1 ns after the edge.
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [3:0] a, input logic [7:0] d);
    rst    = r;
    en_i   = e;
    rw_i   = w;
    addr_i = a;
    data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [7:0] exp_d, input logic exp_v);
    check({name, " data"}, data_o, exp_d);
    check({name, " valid"}, {7'd0, valid_o}, {7'd0, exp_v});
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic e, input logic w,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] ed, input logic ev);
    vec_t v;
    v.name = n; v.rst = r; v.en = e; v.rw = w; v.addr = a; v.data = d;
    v.exp_data = ed; v.exp_valid = ev;
    return v;
  endfunction

  logic [7:0] exp_after_reset;

  initial begin
    rst = 1'b0; en_i = 1'b0; rw_i = 1'b0; addr_i = '0; data_i = '0;
    #2;

    // Reset held 2 cycles with a write presented: must be ignored.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd3, 8'hAA);
      check_out($sformatf("reset cyc%0d", i), 8'h00, 1'b0);
    end

    // Directed table: write/read, hold behaviour, enable gating.
    vecs.push_back(mk("wr 2",        1, 1, 1, 4'd2, 8'h5A, 8'h00, 0));
    vecs.push_back(mk("rd 2",        1, 1, 0, 4'd2, 8'h00, 8'h5A, 1));
    vecs.push_back(mk("idle after",  1, 0, 0, 4'd0, 8'h00, 8'h5A, 0));
    vecs.push_back(mk("wr 5",        1, 1, 1, 4'd5, 8'h33, 8'h5A, 0));
    vecs.push_back(mk("rd 5",        1, 1, 0, 4'd5, 8'h00, 8'h33, 1));
    vecs.push_back(mk("wr 5 hold",   1, 1, 1, 4'd5, 8'h77, 8'h33, 0));
    vecs.push_back(mk("idle1 hold",  1, 0, 0, 4'd5, 8'h00, 8'h33, 0));
    vecs.push_back(mk("idle2 hold",  1, 0, 1, 4'd5, 8'hEE, 8'h33, 0));
    vecs.push_back(mk("idle3 hold",  1, 0, 0, 4'd5, 8'h00, 8'h33, 0));
    vecs.push_back(mk("rd 5 new",    1, 1, 0, 4'd5, 8'h00, 8'h77, 1));
    vecs.push_back(mk("rd 2 again",  1, 1, 0, 4'd2, 8'h00, 8'h5A, 1));
    vecs.push_back(mk("wr 7",        1, 1, 1, 4'd7, 8'h42, 8'h5A, 0));
    vecs.push_back(mk("gate1",       1, 0, 1, 4'd7, 8'h11, 8'h5A, 0));
    vecs.push_back(mk("gate2",       1, 0, 1, 4'd7, 8'h11, 8'h5A, 0));
    vecs.push_back(mk("gate3",       1, 0, 1, 4'd7, 8'h11, 8'h5A, 0));
    vecs.push_back(mk("gate4",       1, 0, 1, 4'd7, 8'h11, 8'h5A, 0));
    vecs.push_back(mk("rd 7 gated",  1, 1, 0, 4'd7, 8'h00, 8'h42, 1));
    vecs.push_back(mk("rd 2 neighb", 1, 1, 0, 4'd2, 8'h00, 8'h5A, 1));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].data);
      check_out(vecs[i].name, vecs[i].exp_data, vecs[i].exp_valid);
    end

    // Reset discards a write of 0xAA to addr 3; the array keeps (or clears) its word.
    step(1'b1, 1'b1, 1'b1, 4'd3, 8'h11);
    step(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    check_out("rd 3 pre-reset", 8'h11, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd3, 8'hAA);
      check_out($sformatf("reset2 cyc%0d", i), 8'h00, 1'b0);
    end
`ifdef SYNC_MEMORY_CLEAR_EN
    exp_after_reset = 8'h00;
`else
    exp_after_reset = 8'h11;
`endif
    step(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    check_out("rd 3 post-reset", exp_after_reset, 1'b1);

    // Full sweep: write k^0xFF everywhere, then 16 back-to-back reads.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b1, 4'(k), 8'(k) ^ 8'hFF);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'(k), 8'h00);
      check_out($sformatf("sweep rd %0d", k), 8'(k) ^ 8'hFF, 1'b1);
    end

    // Reset on the edge that samples the read of addr 3.
    step(1'b1, 1'b1, 1'b0, 4'd1, 8'h00);
    check_out("mid rd 1", 8'hFE, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    check_out("mid rd 2", 8'hFD, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    check_out("mid rd 3 reset", 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd4, 8'h00);
`ifdef SYNC_MEMORY_CLEAR_EN
    check_out("mid rd 4", 8'h00, 1'b1);
`else
    check_out("mid rd 4", 8'hFB, 1'b1);
`endif
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check_out("idle end", data_o === 8'hFB || data_o === 8'h00 ? data_o : 8'hFB, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
